change_dispenser: RTL and testbench
===================================

Name: change_dispenser

Overview:
- Sequential stage directly downstream of the change calculator.
- Accepts a change request (count of 2-unit coins, count of 10-unit notes) with a start pulse.
- Drives the coin/note ejector mechanism one item at a time: notes first, then coins, with a ready handshake, an inter-eject settle gap and a stall timeout.
- Reports busy/done/error status to the top-level vending controller.

Parameters:
- GAP_CYCLES, 3, cycles of settle gap after each eject, counted from the eject cycle itself; legal range 1..15.
- TIMEOUT_CYCLES, 255, maximum cycles to wait for ejectorReady before aborting; 8-bit counter.
- MAX_COINS, 4, largest legal numberOf2Coins request.
- MAX_NOTES, 2, largest legal numberOf10Notes request.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- resetN  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request strobe; ignored unless the block is in IDLE.
- numberOf2Coins  in  3  coins to dispense; sampled only on an accepted start.
- numberOf10Notes  in  2  notes to dispense; sampled only on an accepted start.
- ejectorReady  in  1  mechanism can accept an eject command this cycle.
- coinEject  out  1  one-cycle command to eject one 2-unit coin.
- noteEject  out  1  one-cycle command to eject one 10-unit note.
- coinsLeft  out  3  coins still to dispense.
- notesLeft  out  2  notes still to dispense.
- busy  out  1  a request is in progress.
- done  out  1  one-cycle completion pulse, for success or abort.
- error  out  1  sticky: last request was invalid or timed out; cleared on the next accepted start.

Behaviour:
- Reset (resetN=0 at an edge) forces IDLE from any state, including mid-dispense. All outputs and internal counters go to 0. An eject in flight is dropped, not completed.
- States: IDLE, CHECK, NOTE, COIN, GAP, DONE.
- IDLE:
  - busy=0.
  - start=1 loads coinsLeft and notesLeft from the inputs, clears error, and goes to CHECK.
- CHECK (one cycle, busy=1):
  - numberOf2Coins>MAX_COINS or numberOf10Notes>MAX_NOTES: set error=1, zero both left counters, go to DONE; no ejects are issued.
  - Else notesLeft>0: go to NOTE.
  - Else coinsLeft>0: go to COIN.
  - Else: go to DONE.
- NOTE / COIN (wait for ready):
  - Timeout counter increments each cycle ejectorReady=0.
  - ejectorReady=1: the next cycle has the matching eject output =1 for exactly one cycle, the matching left counter decremented by 1, the timeout counter cleared, and the state is GAP.
  - Timeout counter reaches TIMEOUT_CYCLES: set error=1, go to DONE. Left counters hold their remaining values for diagnosis until the next start.
- GAP:
  - Lasts exactly GAP_CYCLES cycles; the eject pulse is on the first of them.
  - After the gap, route as in CHECK: notes remaining first, then coins, else DONE.
  - ejectorReady is ignored during GAP.
- DONE: one cycle with done=1 and busy=0, then IDLE. A start in the DONE cycle is ignored.
- busy=1 in CHECK, NOTE, COIN and GAP only.
- Never more than one eject output high in a cycle. Eject outputs are never high outside the first GAP cycle.
- A start arriving while busy is ignored, and its inputs are not sampled.
- Counters saturate at 0. No decrement ever occurs at 0, because routing guarantees a nonzero count before NOTE/COIN.
- All outputs are registered; no combinational path from input to output.

Test Plan:
- Nominal, GAP_CYCLES=3: start at cycle 0 with notes=1, coins=2, ejectorReady=1 constant -> noteEject at cycle 3, coinEject at cycles 7 and 11, done at cycle 14, busy=1 on cycles 1-13, final coinsLeft=0, notesLeft=0, error=0.
- Zero change: start with notes=0, coins=0 -> no ejects, done pulse exactly 2 cycles after start, error=0.
- Invalid request: start with coins=5, notes=1 -> no ejects, done 2 cycles after start, error=1, left counters 0. A subsequent valid start clears error on the cycle after it.
- Ready stall and timeout, TIMEOUT_CYCLES=8:
  - notes=2, coins=0, ready held 0 for 5 cycles then 1 -> noteEject the cycle after ready rises, no error.
  - Repeat with ready held 0 permanently -> done and error=1 after 8 waiting cycles, notesLeft=2.
- Start while busy: second start with coins=4 during GAP of a notes=1 request -> ignored; only one noteEject, coinsLeft stays 0.
- Reset mid-operation: resetN=0 during the wait in COIN with coinsLeft=3 -> next cycle all outputs 0 and state IDLE. After release, a new start dispenses normally.

Source files
------------

// File: rtl/change_dispenser.sv
// change_dispenser: ejects the requested notes, then the coins, one at a time.
// Each eject waits for ejectorReady, is followed by a settle gap, and aborts on a stall timeout.
module change_dispenser #(
  parameter int GAP_CYCLES     = 3,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int MAX_COINS      = 4,
  parameter int MAX_NOTES      = 2
) (
  input  logic       clock,
  input  logic       resetN,
  input  logic       start,
  input  logic [2:0] numberOf2Coins,
  input  logic [1:0] numberOf10Notes,
  input  logic       ejectorReady,
  output logic       coinEject,
  output logic       noteEject,
  output logic [2:0] coinsLeft,
  output logic [1:0] notesLeft,
  output logic       busy,
  output logic       done,
  output logic       error
);
  typedef enum logic [2:0] {IDLE, CHECK, NOTE, COIN, GAP, DONE} state_t;
  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0] COIN_MAX = 3'(MAX_COINS);
  localparam logic [1:0] NOTE_MAX = 2'(MAX_NOTES);
  state_t     state;
  state_t     route;
  logic [7:0] tmo;
  logic [3:0] gap;
  // notes always drain before coins
  always_comb route = notesLeft != 2'd0 ? NOTE : coinsLeft != 3'd0 ? COIN : DONE;
  always_ff @(posedge clock) begin
    if (!resetN) begin
      state     <= IDLE;
      tmo       <= 8'd0;
      gap       <= 4'd0;
      coinEject <= 1'b0;
      noteEject <= 1'b0;
      coinsLeft <= 3'd0;
      notesLeft <= 2'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      coinEject <= 1'b0;
      noteEject <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: if (start) begin
          coinsLeft <= numberOf2Coins;
          notesLeft <= numberOf10Notes;
          error     <= 1'b0;
          tmo       <= 8'd0;
          busy      <= 1'b1;
          state     <= CHECK;
        end
        CHECK: if (coinsLeft > COIN_MAX || notesLeft > NOTE_MAX) begin
          error     <= 1'b1;
          coinsLeft <= 3'd0;
          notesLeft <= 2'd0;
          busy      <= 1'b0;
          done      <= 1'b1;
          state     <= DONE;
        end else begin
          busy  <= route != DONE;
          done  <= route == DONE;
          state <= route;
        end
        NOTE, COIN: if (ejectorReady) begin
          noteEject <= state == NOTE;
          coinEject <= state == COIN;
          if (state == NOTE) notesLeft <= notesLeft - 2'd1;
          else coinsLeft <= coinsLeft - 3'd1;
          tmo   <= 8'd0;
          gap   <= 4'd1;
          state <= GAP;
        end else if (tmo == TMO_LAST) begin
          // counters keep the undelivered amounts for diagnosis
          error <= 1'b1;
          tmo   <= 8'd0;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end else begin
          tmo <= tmo + 8'd1;
        end
        GAP: if (gap == GAP_LAST) begin
          busy  <= route != DONE;
          done  <= route == DONE;
          state <= route;
        end else begin
          gap <= gap + 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: directed vectors, corner sequences and random requests
// checked against an eject-schedule model derived from the ready trace.
module tb_change_dispenser;
  localparam int GAP = 3;
  localparam int TO  = 8;
  logic       clock = 1'b0;
  logic       resetN = 1'b0;
  logic       start = 1'b0;
  logic       ejectorReady = 1'b0;
  logic [2:0] numberOf2Coins = 3'd0;
  logic [1:0] numberOf10Notes = 2'd0;
  logic       coinEject, noteEject, busy, done, error;
  logic [2:0] coinsLeft;
  logic [1:0] notesLeft;
  int         checks = 0;
  int         errors = 0;
  bit         rdy[128];

  always #5 clock = ~clock;

  change_dispenser #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .resetN(resetN), .start(start),
    .numberOf2Coins(numberOf2Coins), .numberOf10Notes(numberOf10Notes),
    .ejectorReady(ejectorReady), .coinEject(coinEject), .noteEject(noteEject),
    .coinsLeft(coinsLeft), .notesLeft(notesLeft), .busy(busy), .done(done), .error(error)
  );

  typedef struct {int c; int n; bit r; int dn; bit err; int ej;} vec_t;
  vec_t tbl[8];

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int outs();
    return int'({noteEject, coinEject, notesLeft, coinsLeft, busy, done, error});
  endfunction

  // Runs one request from IDLE using rdy[] as the per-cycle ready trace. bs>0 pulses an
  // extra start (coins=4) in that cycle, bs<0 picks one at random inside the request.
  task automatic run(input int c, input int n, input int bs, output int dcyc,
                     output int ej, output int first_ej, output bit derr);
    bit en[128];
    bit ec[128];
    int t, k, dn, nl, cl, cy1;
    bit er, valid;
    logic [10:0] exp;
    for (int i = 0; i < 128; i++) begin en[i] = 0; ec[i] = 0; end
    valid = c <= 4 && n <= 2;
    er = !valid;
    dn = -1;
    t = 2;
    if (valid) begin
      for (int i = 0; i < n + c && dn < 0; i++) begin
        k = t;
        while (k < t + TO && !rdy[k]) k++;
        if (k == t + TO) begin
          dn = k;
          er = 1;
        end else begin
          if (i < n) en[k + 1] = 1; else ec[k + 1] = 1;
          t = k + 1 + GAP;
        end
      end
      if (dn < 0) dn = t;
    end else dn = 2;
    if (bs < 0) bs = $urandom_range(dn, 1);
    nl = n; cl = c; dcyc = -1; ej = 0; first_ej = -1; derr = 0;
    for (int cy = 0; cy <= dn; cy++) begin
      start = (cy == 0) || (cy == bs);
      numberOf2Coins = cy == 0 ? 3'(c) : 3'd4;
      numberOf10Notes = cy == 0 ? 2'(n) : 2'd0;
      ejectorReady = rdy[cy];
      @(posedge clock); #1;
      cy1 = cy + 1;
      if (!valid && cy1 >= 2) begin nl = 0; cl = 0; end
      if (en[cy1]) nl--;
      if (ec[cy1]) cl--;
      exp = {en[cy1], ec[cy1], 2'(nl), 3'(cl), cy1 < dn, cy1 == dn, cy1 >= dn ? er : 1'b0};
      check($sformatf("c%0d n%0d cycle%0d outputs", c, n, cy1), outs(), int'(exp));
      if (done && dcyc < 0) begin dcyc = cy1; derr = error; end
      if (noteEject || coinEject) begin
        ej++;
        if (first_ej < 0) first_ej = cy1;
      end
    end
    start = 1'b0;
    ejectorReady = 1'b0;
  endtask

  initial begin
    int dcyc, ej, fe, mode;
    bit derr, prev_err;
    tbl = '{
      '{2, 1, 1, 14, 0, 3},
      '{0, 0, 1,  2, 0, 0},
      '{5, 1, 1,  2, 1, 0},
      '{0, 2, 0, 10, 1, 0},
      '{1, 0, 1,  6, 0, 1},
      '{4, 2, 1, 26, 0, 6},
      '{0, 3, 1,  2, 1, 0},
      '{2, 0, 1, 10, 0, 2}
    };
    repeat (2) @(posedge clock);
    #1;
    check("reset outputs", outs(), 0);
    resetN = 1'b1;
    prev_err = 0;
    foreach (tbl[i]) begin
      for (int j = 0; j < 128; j++) rdy[j] = tbl[i].r;
      if (prev_err) check($sformatf("vec%0d sticky error", i), int'(error), 1);
      run(tbl[i].c, tbl[i].n, 0, dcyc, ej, fe, derr);
      check($sformatf("vec%0d done cycle", i), dcyc, tbl[i].dn);
      check($sformatf("vec%0d error", i), int'(derr), int'(tbl[i].err));
      check($sformatf("vec%0d ejects", i), ej, tbl[i].ej);
      prev_err = tbl[i].err;
    end
    // ready stalls for 5 waiting cycles, then rises in cycle 7
    for (int j = 0; j < 128; j++) rdy[j] = j >= 7;
    run(0, 2, 0, dcyc, ej, fe, derr);
    check("stall first eject cycle", fe, 8);
    check("stall error", int'(derr), 0);
    check("stall done cycle", dcyc, 15);
    // second start lands in the settle gap of a one-note request
    for (int j = 0; j < 128; j++) rdy[j] = 1;
    run(0, 1, 4, dcyc, ej, fe, derr);
    check("busy start ejects", ej, 1);
    check("busy start coinsLeft", int'(coinsLeft), 0);
    // reset while waiting in COIN
    for (int j = 0; j < 128; j++) rdy[j] = 0;
    start = 1'b1;
    numberOf2Coins = 3'd3;
    numberOf10Notes = 2'd0;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("pre-reset busy coins", int'({busy, coinsLeft}), 11);
    resetN = 1'b0;
    @(posedge clock); #1;
    resetN = 1'b1;
    check("mid-op reset outputs", outs(), 0);
    @(posedge clock); #1;
    check("post-reset idle", outs(), 0);
    for (int j = 0; j < 128; j++) rdy[j] = 1;
    run(3, 0, 0, dcyc, ej, fe, derr);
    check("post-reset done cycle", dcyc, 14);
    check("post-reset ejects", ej, 3);
    // random requests and ready traces, including invalid sizes and timeouts
    for (int r = 0; r < 40; r++) begin
      mode = $urandom_range(2, 0);
      for (int j = 0; j < 128; j++)
        rdy[j] = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom_range(1, 0)) : ($urandom_range(7, 0) == 0);
      run($urandom_range(7, 0), $urandom_range(3, 0), $urandom_range(1, 0) ? -1 : 0, dcyc, ej, fe, derr);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
